d_cache_axi_bridge: RTL

D_CACHE_AXI_BRIDGE -- requirements
Module: d_cache_axi_bridge

---
 rtl/d_cache_axi_bridge.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/d_cache_axi_bridge.sv
// Bridges the d_cache simple request/response port onto a single-beat AXI master.
// Only one transaction is in flight at a time; AXI id/len/burst/wlast are tied off outside.
module d_cache_axi_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_data_req,
    input  logic        cache_data_wr,
    input  logic [1:0]  cache_data_size,
    input  logic [31:0] cache_data_addr,
    input  logic [31:0] cache_data_wdata,
    output logic [31:0] cache_data_rdata,
    output logic        cache_data_addr_ok,
    output logic        cache_data_data_ok,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        awDone_q, awDone_d;
    logic        wDone_q, wDone_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            size_q   <= 2'd0;
            wdata_q  <= 32'd0;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            awDone_q <= awDone_d;
            wDone_q  <= wDone_d;
        end
    end

    // Every handshake output is gated by rst so nothing is visible while the slave is being reset.
    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        size_d             = size_q;
        wdata_d            = wdata_q;
        awDone_d           = awDone_q;
        wDone_d            = wDone_q;
        cache_data_addr_ok = 1'b0;
        cache_data_data_ok = 1'b0;
        arvalid            = 1'b0;
        rready             = 1'b0;
        awvalid            = 1'b0;
        wvalid             = 1'b0;
        bready             = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (cache_data_req) begin
                        cache_data_addr_ok = 1'b1;
                        addr_d             = cache_data_addr;
                        size_d             = cache_data_size;
                        wdata_d            = cache_data_wdata;
                        state_d            = cache_data_wr ? WR_A : RD_A;
                    end
                end
                RD_A: begin
                    arvalid = 1'b1;
                    if (arready) begin
                        state_d = RD_D;
                    end
                end
                RD_D: begin
                    rready = 1'b1;
                    if (rvalid) begin
                        cache_data_data_ok = 1'b1;
                        state_d            = IDLE;
                    end
                end
                WR_A: begin
                    // AW and W complete independently; the flags remember whichever finished first.
                    awvalid  = !awDone_q;
                    wvalid   = !wDone_q;
                    awDone_d = awDone_q | (awvalid & awready);
                    wDone_d  = wDone_q | (wvalid & wready);
                    if (awDone_d && wDone_d) begin
                        state_d  = WR_B;
                        awDone_d = 1'b0;
                        wDone_d  = 1'b0;
                    end
                end
                WR_B: begin
                    bready = 1'b1;
                    if (bvalid) begin
                        cache_data_data_ok = 1'b1;
                        state_d            = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Byte lanes are already placed by the core, so only the strobes depend on the address.
    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign araddr           = addr_q;
    assign awaddr           = addr_q;
    assign arsize           = {1'b0, size_q};
    assign awsize           = {1'b0, size_q};
    assign wdata            = wdata_q;
    assign cache_data_rdata = rdata;

endmodule
